// File: rtl/alu_pkg.sv
// Shared constants for the four-bit ALU logic group: datapath width and the
// operation encoding used by the parent ALU result mux.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_NOT = 2'd3
    } logic_op_e;

endpackage

// File: rtl/or_4_or_bit.sv
// Single-bit OR cell; a 1 on either input dominates any x/z on the other.
module or_bit (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i | b_i;

endmodule

// File: rtl/or_4.sv
// Bitwise OR unit with zero/all-ones flags and an optional registered result.
// The combinational result and flags never depend on clk or rst.
module or_4
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             zero,
    output logic             ones
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            or_bit u_or_bit (
                .a_i (a[gi]),
                .b_i (b[gi]),
                .y_o (y[gi])
            );
        end
    endgenerate

    assign zero = ~|y;
    assign ones = &y;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] res_q;
            logic [WIDTH-1:0] res_d;

            always_comb begin
                res_d = res_q;
                if (en) begin
                    res_d = y;
                end
            end

            // Reset acts immediately, without waiting for a clock edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else begin
                    res_q <= res_d;
                end
            end

            assign y_q = res_q;
        end else begin : g_comb
            assign y_q = y;
        end
    endgenerate

endmodule

// File: tb/tb_or_4.sv
// Directed self-checking bench for or_4: combinational OR and flags, exhaustive
// sweep, asynchronous reset, load enable hold, and undriven clock/reset.
module tb_or_4;

    logic       clk_gen = 1'b0;
    logic       clk_run = 1'b1;
    wire        clk;
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [3:0] y_q;
    logic       zero;
    logic       ones;

    int checks = 0;
    int errors = 0;

    always #5 clk_gen = ~clk_gen;
    assign clk = clk_run ? clk_gen : 1'bz;

    or_4 #(.WIDTH(4), .REG_OUT(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .a    (a),
        .b    (b),
        .y    (y),
        .y_q  (y_q),
        .zero (zero),
        .ones (ones)
    );

    logic [3:0] va [7] = '{4'b0000, 4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b0000, 4'b0101};
    logic [3:0] vb [7] = '{4'b0000, 4'b1111, 4'b1100, 4'b1001, 4'b0000, 4'b1111, 4'b0011};
    logic [3:0] vy [7] = '{4'b0000, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b0111};
    logic       vz [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       vo [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic run_comb(input string tag);
        for (int i = 0; i < 7; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            checks++;
            if (y !== vy[i] || zero !== vz[i] || ones !== vo[i]) begin
                errors++;
                $display("FAIL %s vec%0d: a=%b b=%b got y=%b zero=%b ones=%b, expected y=%b zero=%b ones=%b",
                         tag, i, a, b, y, zero, ones, vy[i], vz[i], vo[i]);
            end else begin
                $display("%s vec%0d: a=%b b=%b y=%b zero=%b ones=%b ok", tag, i, a, b, y, zero, ones);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        a   = 4'b1111;
        b   = 4'b0000;
        repeat (2) @(posedge clk_gen);
        #1;
        checks++;
        if (y_q !== 4'b0000) begin
            errors++;
            $display("FAIL reset_yq: got %b expected 0000", y_q);
        end else begin
            $display("reset: y_q=%b held low under rst", y_q);
        end
        @(negedge clk_gen);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_comb_vectors();
        run_comb("comb");
    endtask

    task automatic test_exhaustive();
        int mism;
        logic [3:0] exp_y;
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = i[3:0];
                b = j[3:0];
                #1;
                exp_y = i[3:0] | j[3:0];
                if (y !== exp_y || zero !== (exp_y == 4'b0000) || ones !== (exp_y == 4'b1111))
                    mism++;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL exhaustive: %0d mismatches over 256 pairs, expected 0", mism);
        end else begin
            $display("exhaustive: 256 pairs, %0d mismatches", mism);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk_gen);
        a  = 4'b1010;
        b  = 4'b1100;
        en = 1'b1;
        @(posedge clk_gen);
        #1;
        checks++;
        if (y_q !== 4'b1110) begin
            errors++;
            $display("FAIL load_1110: got %b expected 1110", y_q);
        end else begin
            $display("load: y_q=%b", y_q);
        end
        @(negedge clk_gen);
        rst = 1'b1;
        #1;
        checks++;
        if (y_q !== 4'b0000) begin
            errors++;
            $display("FAIL async_clear: got %b expected 0000 before next edge", y_q);
        end else begin
            $display("async reset: y_q=%b between edges", y_q);
        end
        @(posedge clk_gen);
        #1;
        checks++;
        if (y_q !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 0000 while rst high", y_q);
        end else begin
            $display("reset hold: y_q=%b across edge", y_q);
        end
        @(negedge clk_gen);
        rst = 1'b0;
        a   = 4'b0101;
        b   = 4'b0011;
        en  = 1'b1;
        @(posedge clk_gen);
        #1;
        checks++;
        if (y_q !== 4'b0111) begin
            errors++;
            $display("FAIL post_reset_load: got %b expected 0111", y_q);
        end else begin
            $display("post-reset load: y_q=%b", y_q);
        end
    endtask

    task automatic test_hold();
        @(negedge clk_gen);
        en = 1'b0;
        a  = 4'b1111;
        b  = 4'b1111;
        repeat (2) begin
            @(posedge clk_gen);
            #1;
            checks++;
            if (y_q !== 4'b0111 || y !== 4'b1111) begin
                errors++;
                $display("FAIL hold: got y_q=%b y=%b expected y_q=0111 y=1111", y_q, y);
            end else begin
                $display("hold: y_q=%b y=%b", y_q, y);
            end
        end
    endtask

    task automatic test_xprop();
        a = 4'b1xxx;
        b = 4'b0000;
        #1;
        checks++;
        if (y[3] !== 1'b1) begin
            errors++;
            $display("FAIL xprop_msb: got y=%b expected y[3]=1", y);
        end else begin
            $display("xprop: a=%b b=%b y=%b", a, b, y);
        end
        a = 4'bxxxx;
        b = 4'b1111;
        #1;
        checks++;
        if (y !== 4'b1111 || ones !== 1'b1) begin
            errors++;
            $display("FAIL xprop_force: got y=%b ones=%b expected y=1111 ones=1", y, ones);
        end else begin
            $display("xprop: a=%b b=%b y=%b", a, b, y);
        end
    endtask

    task automatic test_unconnected();
        clk_run = 1'b0;
        rst     = 1'bz;
        en      = 1'bz;
        #1;
        run_comb("noclk");
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        test_reset();
        test_comb_vectors();
        test_exhaustive();
        test_async_reset();
        test_hold();
        test_xprop();
        test_unconnected();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
